alu_cmd_unit: RTL and testbench
===============================

# alu_cmd_unit

Sequential command front-end for the 32-bit ripple `ALU`, and the hardware counterpart of the ALU bench stimulus.
- Accepts one operation command per valid/ready handshake and translates it to the ALU's `Binvert`/`Carryin`/`Operation` controls.
- Holds operands stable for a fixed settle time, then registers result, carry, zero and overflow and returns them on a valid/ready response channel.
- Sits between the datapath control (or a bus slave) and the combinational ALU.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width; must match the instantiated `ALU`.
- `LAT`, 1, ALU settle cycles between operand latch and result capture; legal range 1..15.

Ports:
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `cmd_valid`  input  1  command present.
- `cmd_ready`  output  1  unit can accept a command.
- `cmd_op`  input  3  opcode: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT; all other codes are illegal.
- `cmd_a`, `cmd_b`  input  WIDTH  operands.
- `rsp_valid`  output  1  response present.
- `rsp_ready`  input  1  consumer takes the response.
- `rsp_result`  output  WIDTH  registered result.
- `rsp_carry`  output  1  ALU CarryOut for ADD/SUB/SLT; 0 for AND/OR.
- `rsp_zero`  output  1  `rsp_result == 0`.
- `rsp_ovf`  output  1  signed overflow for ADD/SUB/SLT; 0 otherwise.
- `rsp_err`  output  1  illegal opcode.

## Operation
FSM states IDLE, EXEC, RESP; reset state is IDLE.
- **IDLE**
  - `cmd_ready`=1.
  - On `cmd_valid`: latch `cmd_a`, `cmd_b`, `cmd_op` into operand registers; load `cnt`=LAT-1; go to EXEC.
- **EXEC**
  - `cmd_ready`=0.
  - The ALU is driven only from the operand registers.
  - If `cnt`≠0, decrement. If `cnt`==0, capture all `rsp_*` and go to RESP.
- **RESP**
  - `rsp_valid`=1; all `rsp_*` outputs held constant.
  - On `rsp_ready`, go to IDLE.
  - `cmd_ready`=0: no overlap of command and response.

ALU control decode (registered op):
- AND: Operation 00, Binvert 0, Carryin 0.
- OR: Operation 01, Binvert 0, Carryin 0.
- ADD: Operation 10, Binvert 0, Carryin 0.
- SUB and SLT: Operation 10, Binvert 1, Carryin 1.
- Illegal opcode: AND controls; `rsp_result`=0, `rsp_err`=1, carry/ovf 0, zero 1.

Flag and width rules:
- Overflow: ADD is `a[W-1]==b[W-1] && s[W-1]!=a[W-1]`. SUB/SLT is `a[W-1]!=b[W-1] && s[W-1]!=a[W-1]`.
- SLT result: `{(W-1)'b0, s[W-1]^ovf}`. `rsp_carry` and `rsp_ovf` report the underlying subtraction. `rsp_zero` is computed on the final SLT result.
- All arithmetic is modulo 2^WIDTH; no saturation.

## Timing
- Reset values: `cmd_ready`=0 during the `rst` cycle and 1 after; `rsp_valid`=0; `rsp_result`=0; `rsp_carry`/`rsp_zero`/`rsp_ovf`/`rsp_err`=0; `cnt`=0; FSM=IDLE.
- Accept edge N is the edge with `cmd_valid && cmd_ready`. `rsp_valid` rises after edge N+LAT. Minimum command-to-command period is LAT+2 cycles.
- While `rsp_valid` is high and `rsp_ready` is low, every `rsp_*` output is stable for any number of cycles.
- `rsp_valid && rsp_ready` at edge M: `rsp_valid`=0 and `cmd_ready`=1 after M. A command presented in that same cycle is not accepted until edge M+1.
- `cmd_*` changes during EXEC/RESP are ignored.
- `rst` in any state (including mid-EXEC and stalled RESP) returns to IDLE on that edge; the in-flight command is dropped with no response.
- `rst` takes priority over simultaneous handshakes.

## Structure
- `alu_pkg` holds:
  - opcode constants (`OP_AND`, `OP_OR`, `OP_ADD`, `OP_SUB`, `OP_SLT`);
  - ALU `Operation` encodings;
  - the FSM state enum.
- One sub-module: the existing `ALU`, instantiated once and fed from the operand registers.
- Decode, flag logic, counter and FSM live in `alu_cmd_unit`; no further sub-modules.

## Test plan
1. a=A5A5A5A5, b=5A5A5A5A, LAT=1:
   - AND → result 00000000, zero=1, carry=0.
   - OR → FFFFFFFF.
   - ADD → FFFFFFFF, carry=0, ovf=0.
   - Each response has `rsp_valid` one edge after the accept edge.
2. Same operands:
   - SUB → 4B4B4B4B, carry=1, ovf=1.
   - SLT → 00000001, carry=1, ovf=1, zero=0.
3. ADD 7FFFFFFF+00000001 → 80000000, ovf=1, carry=0. ADD FFFFFFFF+00000001 → 00000000, carry=1, zero=1, ovf=0.
4. LAT=4, `rsp_ready` held low 3 cycles after `rsp_valid` rises:
   - `rsp_valid` appears 4 edges after accept.
   - Outputs stable for the 3 stall cycles; `cmd_ready`=0 throughout.
   - `cmd_ready`=1 after the `rsp_ready` edge.
5. `cmd_op`=011 → `rsp_err`=1, result 0, zero=1. Next legal command completes normally with `rsp_err`=0.
6. `rst` pulsed mid-EXEC (LAT=4, second cycle) → no `rsp_valid`; all outputs at reset values; `cmd_ready`=1 the following cycle; fresh ADD 2+3 → 00000005.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command front-end.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
//
// Contents: command opcodes, ALU Operation encodings, command FSM state enum.
package alu_pkg;

  // Command opcodes seen on cmd_op
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  // ALU Operation select encodings
  localparam logic [1:0] ALU_AND = 2'b00;
  localparam logic [1:0] ALU_OR  = 2'b01;
  localparam logic [1:0] ALU_ADD = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_RESP = 2'b10
  } state_t;

endpackage

// File: rtl/ALU.sv
// Combinational ripple-carry ALU: AND / OR / ADD with optional B inversion.
// Latency: purely combinational, no registers.
// Backpressure: none; output follows inputs after ripple settle.
//
// Ports: a, b            operands
//        Binvert         invert b before the logic/adder stage
//        Carryin         carry into bit 0
//        Operation       00 AND, 01 OR, 10 ADD, 11 yields zero
//        Result          selected result
//        CarryOut        carry out of the MSB of the adder
module ALU #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             Binvert,
  input  logic             Carryin,
  input  logic [1:0]       Operation,
  output logic [WIDTH-1:0] Result,
  output logic             CarryOut
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum;

  assign b_eff = b ^ {WIDTH{Binvert}};

  // Bit-serial ripple chain; c carries from one bit slice to the next.
  always_comb begin
    logic c;
    sum = '0;
    c   = Carryin;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i] = a[i] ^ b_eff[i] ^ c;
      c      = (a[i] & b_eff[i]) | (c & (a[i] ^ b_eff[i]));
    end
    CarryOut = c;
  end

  always_comb begin
    case (Operation)
      2'b00:   Result = a & b_eff;
      2'b01:   Result = a | b_eff;
      2'b10:   Result = sum;
      default: Result = '0;
    endcase
  end

endmodule

// File: rtl/alu_cmd_unit.sv
// Command front-end for the ripple ALU: one command in, one registered result out.
// Latency: rsp_valid rises LAT edges after the accept edge; next command one cycle after rsp handshake.
// Backpressure: cmd_ready only in IDLE; response held stable in RESP until rsp_ready.
//
// Ports: clk, rst (sync, active high)
//        cmd_valid/cmd_ready, cmd_op[2:0], cmd_a, cmd_b   command channel
//        rsp_valid/rsp_ready, rsp_result, rsp_carry, rsp_zero, rsp_ovf, rsp_err   response channel
module alu_cmd_unit #(
  parameter int WIDTH = 32,
  parameter int LAT   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carry,
  output logic             rsp_zero,
  output logic             rsp_ovf,
  output logic             rsp_err
);

  import alu_pkg::*;

  localparam logic [3:0] CNT_LOAD = 4'(LAT - 1);

  state_t           state, state_n;
  logic [3:0]       cnt;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;

  logic [1:0]       alu_operation;
  logic             alu_binvert, alu_carryin;
  logic [WIDTH-1:0] alu_result;
  logic             alu_carry;

  logic             ovf_add, ovf_sub;
  logic [WIDTH-1:0] res_n;
  logic             carry_n, ovf_n, err_n;
  logic             capture;

  // ALU sees only the latched operands, never the live command bus.
  ALU #(.WIDTH(WIDTH)) u_alu (
    .a         (a_q),
    .b         (b_q),
    .Binvert   (alu_binvert),
    .Carryin   (alu_carryin),
    .Operation (alu_operation),
    .Result    (alu_result),
    .CarryOut  (alu_carry)
  );

  // Control decode; illegal opcodes fall back to harmless AND controls.
  always_comb begin
    alu_operation = ALU_AND;
    alu_binvert   = 1'b0;
    alu_carryin   = 1'b0;
    case (op_q)
      OP_OR:  alu_operation = ALU_OR;
      OP_ADD: alu_operation = ALU_ADD;
      OP_SUB, OP_SLT: begin
        alu_operation = ALU_ADD;
        alu_binvert   = 1'b1;
        alu_carryin   = 1'b1;
      end
      default: ;
    endcase
  end

  // Signed overflow from operand/sum sign bits; subtraction flips the b-sign test.
  assign ovf_add = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (alu_result[WIDTH-1] != a_q[WIDTH-1]);
  assign ovf_sub = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (alu_result[WIDTH-1] != a_q[WIDTH-1]);

  always_comb begin
    res_n   = alu_result;
    carry_n = 1'b0;
    ovf_n   = 1'b0;
    err_n   = 1'b0;
    case (op_q)
      OP_AND, OP_OR: ;
      OP_ADD: begin
        carry_n = alu_carry;
        ovf_n   = ovf_add;
      end
      OP_SUB: begin
        carry_n = alu_carry;
        ovf_n   = ovf_sub;
      end
      OP_SLT: begin
        // True signed less-than: sign of difference corrected by overflow.
        res_n    = '0;
        res_n[0] = alu_result[WIDTH-1] ^ ovf_sub;
        carry_n  = alu_carry;
        ovf_n    = ovf_sub;
      end
      default: begin
        res_n = '0;
        err_n = 1'b1;
      end
    endcase
  end

  // FSM next-state
  always_comb begin
    state_n = state;
    capture = 1'b0;
    case (state)
      S_IDLE: if (cmd_valid) state_n = S_EXEC;
      S_EXEC: if (cnt == 4'd0) begin
        capture = 1'b1;
        state_n = S_RESP;
      end
      S_RESP: if (rsp_ready) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
      rsp_zero   <= 1'b0;
      rsp_ovf    <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      if (state == S_IDLE && cmd_valid) begin
        op_q <= cmd_op;
        a_q  <= cmd_a;
        b_q  <= cmd_b;
        cnt  <= CNT_LOAD;
      end else if (state == S_EXEC && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (capture) begin
        rsp_result <= res_n;
        rsp_carry  <= carry_n;
        rsp_zero   <= (res_n == '0);
        rsp_ovf    <= ovf_n;
        rsp_err    <= err_n;
      end
    end
  end

  // cmd_ready is gated by rst so it reads 0 through the reset cycle.
  assign cmd_ready = (state == S_IDLE) && !rst;
  assign rsp_valid = (state == S_RESP);

endmodule

// File: tb/tb_alu_cmd_unit.sv
module tb_alu_cmd_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Index 0: LAT=1 instance, index 1: LAT=4 instance
  logic        rst       [2];
  logic        cmd_valid [2];
  logic        cmd_ready [2];
  logic [2:0]  cmd_op    [2];
  logic [31:0] cmd_a     [2];
  logic [31:0] cmd_b     [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_result[2];
  logic        rsp_carry [2];
  logic        rsp_zero  [2];
  logic        rsp_ovf   [2];
  logic        rsp_err   [2];

  alu_cmd_unit #(.WIDTH(32), .LAT(1)) dut0 (
    .clk(clk), .rst(rst[0]),
    .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_op(cmd_op[0]),
    .cmd_a(cmd_a[0]), .cmd_b(cmd_b[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_result(rsp_result[0]),
    .rsp_carry(rsp_carry[0]), .rsp_zero(rsp_zero[0]), .rsp_ovf(rsp_ovf[0]), .rsp_err(rsp_err[0])
  );

  alu_cmd_unit #(.WIDTH(32), .LAT(4)) dut1 (
    .clk(clk), .rst(rst[1]),
    .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_op(cmd_op[1]),
    .cmd_a(cmd_a[1]), .cmd_b(cmd_b[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_result(rsp_result[1]),
    .rsp_carry(rsp_carry[1]), .rsp_zero(rsp_zero[1]), .rsp_ovf(rsp_ovf[1]), .rsp_err(rsp_err[1])
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0] r;
    logic        c, z, o, e;
  } exp_t;

  // Reference: plain integer arithmetic on wide signed/unsigned values.
  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        x;
    longint      sa, sb, s;
    logic [32:0] w;
    logic [31:0] d;
    x  = '0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    d  = a - b;
    case (op)
      3'b000: x.r = a & b;
      3'b001: x.r = a | b;
      3'b010: begin
        w   = {1'b0, a} + {1'b0, b};
        x.r = w[31:0];
        x.c = w[32];
        s   = sa + sb;
        x.o = (s != longint'($signed(x.r)));
      end
      3'b110, 3'b111: begin
        s   = sa - sb;
        x.c = (a >= b);              // no borrow
        x.o = (s != longint'($signed(d)));
        x.r = (op == 3'b110) ? d : ((sa < sb) ? 32'd1 : 32'd0);
      end
      default: x.e = 1'b1;
    endcase
    x.z = (x.r == 32'd0);
    return x;
  endfunction

  // Full command/response transaction with latency, stall and release checks.
  task automatic run_cmd(input int i, input int lat, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b, input int stall,
                         input exp_t ex, input string tag);
    int n;
    @(negedge clk);
    chk({tag, " cmd_ready before accept"}, 32'(cmd_ready[i]), 32'd1);
    cmd_valid[i] = 1'b1; cmd_op[i] = op; cmd_a[i] = a; cmd_b[i] = b;
    @(posedge clk); #1;
    // Scramble the command bus; the unit must ignore it now.
    cmd_valid[i] = 1'b0; cmd_op[i] = 3'($urandom); cmd_a[i] = $urandom; cmd_b[i] = $urandom;
    n = 0;
    while (!rsp_valid[i] && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, " latency"}, 32'(n), 32'(lat));
    for (int s = 0; s <= stall; s++) begin
      if (s > 0) begin
        @(posedge clk); #1;
      end
      chk({tag, " rsp_valid"},  32'(rsp_valid[i]), 32'd1);
      chk({tag, " result"},     rsp_result[i],     ex.r);
      chk({tag, " carry"},      32'(rsp_carry[i]), 32'(ex.c));
      chk({tag, " zero"},       32'(rsp_zero[i]),  32'(ex.z));
      chk({tag, " ovf"},        32'(rsp_ovf[i]),   32'(ex.o));
      chk({tag, " err"},        32'(rsp_err[i]),   32'(ex.e));
      chk({tag, " cmd_ready in RESP"}, 32'(cmd_ready[i]), 32'd0);
    end
    @(negedge clk);
    rsp_ready[i] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[i] = 1'b0;
    chk({tag, " rsp_valid after handshake"}, 32'(rsp_valid[i]), 32'd0);
    chk({tag, " cmd_ready after handshake"}, 32'(cmd_ready[i]), 32'd1);
  endtask

  task automatic chk_reset_vals(input int i, input string tag);
    chk({tag, " cmd_ready"},  32'(cmd_ready[i]), 32'd0);
    chk({tag, " rsp_valid"},  32'(rsp_valid[i]), 32'd0);
    chk({tag, " result"},     rsp_result[i],     32'd0);
    chk({tag, " carry"},      32'(rsp_carry[i]), 32'd0);
    chk({tag, " zero"},       32'(rsp_zero[i]),  32'd0);
    chk({tag, " ovf"},        32'(rsp_ovf[i]),   32'd0);
    chk({tag, " err"},        32'(rsp_err[i]),   32'd0);
  endtask

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a, b;
    exp_t        ex;
  } vec_t;

  vec_t        tbl[11];
  logic [31:0] corner[5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t ex;
    logic seen;

    tbl[0]  = '{3'b000, 32'hA5A5A5A5, 32'h5A5A5A5A, '{32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0}};
    tbl[1]  = '{3'b001, 32'hA5A5A5A5, 32'h5A5A5A5A, '{32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0}};
    tbl[2]  = '{3'b010, 32'hA5A5A5A5, 32'h5A5A5A5A, '{32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0}};
    tbl[3]  = '{3'b110, 32'hA5A5A5A5, 32'h5A5A5A5A, '{32'h4B4B4B4B, 1'b1, 1'b0, 1'b1, 1'b0}};
    tbl[4]  = '{3'b111, 32'hA5A5A5A5, 32'h5A5A5A5A, '{32'h00000001, 1'b1, 1'b0, 1'b1, 1'b0}};
    tbl[5]  = '{3'b010, 32'h7FFFFFFF, 32'h00000001, '{32'h80000000, 1'b0, 1'b0, 1'b1, 1'b0}};
    tbl[6]  = '{3'b010, 32'hFFFFFFFF, 32'h00000001, '{32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0}};
    tbl[7]  = '{3'b011, 32'h12345678, 32'h9ABCDEF0, '{32'h00000000, 1'b0, 1'b1, 1'b0, 1'b1}};
    tbl[8]  = '{3'b110, 32'h00000005, 32'h00000005, '{32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0}};
    tbl[9]  = '{3'b111, 32'h5A5A5A5A, 32'hA5A5A5A5, '{32'h00000000, 1'b0, 1'b1, 1'b1, 1'b0}};
    tbl[10] = '{3'b100, 32'hFFFFFFFF, 32'hFFFFFFFF, '{32'h00000000, 1'b0, 1'b1, 1'b0, 1'b1}};

    corner[0] = 32'h00000000; corner[1] = 32'hFFFFFFFF; corner[2] = 32'h7FFFFFFF;
    corner[3] = 32'h80000000; corner[4] = 32'h00000001;

    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; cmd_valid[i] = 1'b0; rsp_ready[i] = 1'b0;
      cmd_op[i] = '0; cmd_a[i] = '0; cmd_b[i] = '0;
    end

    // Reset state, then cmd_ready rising once rst drops
    @(posedge clk); #1;
    chk_reset_vals(0, "reset0");
    chk_reset_vals(1, "reset1");
    @(negedge clk);
    rst[0] = 1'b0; rst[1] = 1'b0;
    #1;
    chk("cmd_ready after reset 0", 32'(cmd_ready[0]), 32'd1);
    chk("cmd_ready after reset 1", 32'(cmd_ready[1]), 32'd1);

    // Directed vectors on the LAT=1 instance
    for (int k = 0; k < 11; k++)
      run_cmd(0, 1, tbl[k].op, tbl[k].a, tbl[k].b, 0, tbl[k].ex, $sformatf("vec%0d", k));

    // LAT=4 with a 3-cycle response stall
    run_cmd(1, 4, 3'b010, 32'h12345678, 32'h11111111, 3,
            '{32'h23456789, 1'b0, 1'b0, 1'b0, 1'b0}, "stall");

    // Command presented during the response handshake waits one more edge
    @(negedge clk);
    cmd_valid[0] = 1'b1; cmd_op[0] = 3'b010; cmd_a[0] = 32'd1; cmd_b[0] = 32'd1;
    @(posedge clk); #1;
    cmd_op[0] = 3'b001; cmd_a[0] = 32'h0F0F0000; cmd_b[0] = 32'h000000F0;
    @(posedge clk); #1;
    chk("overlap first rsp_valid", 32'(rsp_valid[0]), 32'd1);
    chk("overlap first result", rsp_result[0], 32'd2);
    rsp_ready[0] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[0] = 1'b0;
    chk("overlap rsp_valid low at M", 32'(rsp_valid[0]), 32'd0);
    chk("overlap cmd_ready high at M", 32'(cmd_ready[0]), 32'd1);
    @(posedge clk); #1;
    cmd_valid[0] = 1'b0;
    chk("overlap accepted at M+1", 32'(cmd_ready[0]), 32'd0);
    chk("overlap no rsp yet", 32'(rsp_valid[0]), 32'd0);
    @(posedge clk); #1;
    chk("overlap second rsp_valid", 32'(rsp_valid[0]), 32'd1);
    chk("overlap second result", rsp_result[0], 32'h0F0F00F0);
    rsp_ready[0] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[0] = 1'b0;

    // Reset during EXEC drops the command
    @(negedge clk);
    cmd_valid[1] = 1'b1; cmd_op[1] = 3'b010; cmd_a[1] = 32'd7; cmd_b[1] = 32'd8;
    @(posedge clk); #1;
    cmd_valid[1] = 1'b0;
    @(posedge clk); #1;
    rst[1] = 1'b1;
    @(posedge clk); #1;
    chk_reset_vals(1, "midexec reset");
    @(negedge clk);
    rst[1] = 1'b0;
    #1;
    chk("midexec cmd_ready after rst", 32'(cmd_ready[1]), 32'd1);
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      seen |= rsp_valid[1];
    end
    chk("midexec no response", 32'(seen), 32'd0);
    run_cmd(1, 4, 3'b010, 32'd2, 32'd3, 0, '{32'd5, 1'b0, 1'b0, 1'b0, 1'b0}, "post-reset add");

    // Randomized commands on both instances against the reference model
    for (int k = 0; k < 60; k++) begin
      int          i;
      logic [2:0]  op;
      logic [31:0] a, b;
      i  = k % 2;
      op = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
      ex = model(op, a, b);
      run_cmd(i, (i == 0) ? 1 : 4, op, a, b, $urandom_range(0, 2), ex,
              $sformatf("rand%0d op%0b", k, op));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
